// File: rtl/jtag_sched_pkg.sv
// Shared types and frame layout for the JTAG TX scheduler.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package jtag_sched_pkg;

    // Scan-chain protocol phase as seen by the scheduler
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOADED = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_DONE   = 2'd3
    } jt_state_t;

    // Payload byte carried in every frame
    localparam int DATA_W = 8;

    // Frame layout, LSB first on TDO: valid flag, source id, payload
    localparam int VALID_BIT = 0;
    localparam int ID_LSB    = 1;

    function automatic int data_lsb(input int id_w);
        return 1 + id_w;
    endfunction

    function automatic int dr_w(input int id_w);
        return 1 + id_w + DATA_W;
    endfunction

endpackage

// File: rtl/jtag_rr_arbiter.sv
// Picks one requester for the frame being captured (round-robin, or fixed priority
// when JTAG_TX_STRICT_PRIO_EN is defined). Latency: purely combinational.
// Backpressure: none; the grant is only consumed when the caller captures.
module jtag_rr_arbiter #(
    parameter int N_SRC = 2,
    parameter int ID_W  = 2
)(
    input  logic [N_SRC-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_SRC-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             grant_vld
);

`ifdef JTAG_TX_STRICT_PRIO_EN
    // The last-grant pointer has no meaning under fixed priority
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Lowest index wins: scan downwards so the last hit is the lowest index
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = ID_W'(i);
                grant_vld = 1'b1;
            end
        end
    end
`else
    // Search starts just after the last winner; scan farthest-first so the
    // nearest candidate overwrites and ends up holding the grant
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int k = N_SRC; k >= 1; k--) begin
            idx = (int'(ptr) + k) % N_SRC;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
                grant_vld  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/jtag_tx_sched.sv
// Multiplexes N_SRC byte sources onto a JTAG user DR and captures host words
// shifted back in. Latency: frame LSB on jt_tdo the cycle after Capture-DR.
// Backpressure: sources are popped one word per capture; the host paces everything.
// Build option: JTAG_TX_STRICT_PRIO_EN selects fixed-priority arbitration.
module jtag_tx_sched
    import jtag_sched_pkg::*;
#(
    parameter  int N_SRC = 2,
    parameter  int ID_W  = 2,
    localparam int DR_W  = dr_w(ID_W)
)(
    input  logic                jt_tck,
    input  logic                jt_reset,
    input  logic                jt_sel,
    input  logic                jt_capture,
    input  logic                jt_shift,
    input  logic                jt_update,
    input  logic                jt_tdi,
    output logic                jt_tdo,
    input  logic [N_SRC-1:0]    src_valid,
    input  logic [8*N_SRC-1:0]  src_data,
    output logic [N_SRC-1:0]    src_ack,
    output logic [DR_W-1:0]     rx_word,
    output logic                rx_valid,
    output logic                rx_err
);

    localparam int               CNT_W    = $clog2(DR_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DR_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DR_W + 1);
    localparam logic [ID_W-1:0]  PTR_RST  = ID_W'(N_SRC - 1);
    localparam int               DATA_LSB = data_lsb(ID_W);

    jt_state_t          state;
    jt_state_t          state_nxt;
    logic [DR_W-1:0]    dr;
    logic [CNT_W-1:0]   shift_cnt;
    logic [ID_W-1:0]    rr_ptr;

    logic [N_SRC-1:0]   grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_vld;
    logic [DATA_W-1:0]  sel_data;
    logic [DR_W-1:0]    frame;

    // Update outranks capture outranks shift if the TAP ever presents several
    logic up_en;
    logic cap_en;
    logic sh_en;
    assign up_en  = jt_sel & jt_update;
    assign cap_en = jt_sel & jt_capture & ~jt_update;
    assign sh_en  = jt_sel & jt_shift & ~jt_capture & ~jt_update;

    jtag_rr_arbiter #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_arb (
        .req       (src_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    // Head word of the granted source
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant[i]) begin
                sel_data = src_data[8*i +: 8];
            end
        end
    end

    // Frame assembled from the grant: valid flag, source id, payload
    always_comb begin
        frame                      = '0;
        frame[VALID_BIT]           = 1'b1;
        frame[ID_LSB +: ID_W]      = grant_idx;
        frame[DATA_LSB +: DATA_W]  = sel_data;
    end

    // State register
    always_ff @(posedge jt_tck or posedge jt_reset) begin
        if (jt_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic tracking the DR scan phase
    always_comb begin
        state_nxt = state;
        if (up_en) begin
            state_nxt = ST_DONE;
        end else if (cap_en && (state == ST_IDLE || state == ST_DONE)) begin
            state_nxt = ST_LOADED;
        end else if (sh_en && (state == ST_LOADED || state == ST_SHIFT)) begin
            state_nxt = ST_SHIFT;
        end
    end

    // Pop strobe only in the capture cycle; TDO is the DR LSB
    always_comb begin
        src_ack = '0;
        if (cap_en && !jt_reset) begin
            src_ack = grant;
        end
        jt_tdo = dr[0];
    end

    // Data register, shift counter and round-robin pointer
    always_ff @(posedge jt_tck or posedge jt_reset) begin
        if (jt_reset) begin
            dr        <= '0;
            shift_cnt <= '0;
            rr_ptr    <= PTR_RST;
        end else if (cap_en) begin
            dr        <= grant_vld ? frame : '0;
            shift_cnt <= '0;
            if (grant_vld) begin
                rr_ptr <= grant_idx;
            end
        end else if (sh_en) begin
            dr <= {jt_tdi, dr[DR_W-1:1]};
            if (shift_cnt != CNT_SAT) begin
                shift_cnt <= shift_cnt + 1'b1;
            end
        end
    end

    // Host word delivery: accepted only after a full-length shift of a captured DR
    always_ff @(posedge jt_tck or posedge jt_reset) begin
        if (jt_reset) begin
            rx_word  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            if (up_en) begin
                if (state != ST_IDLE && shift_cnt == CNT_FULL) begin
                    rx_word  <= dr;
                    rx_valid <= 1'b1;
                end else begin
                    rx_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtag_tx_sched.sv
// Bench for jtag_tx_sched: randomized JTAG scans against a queue-based model.
// Latency: n/a. Backpressure: sources modelled as FWFT queues popped on src_ack.
module tb_jtag_tx_sched;

    localparam int N_SRC = 2;
    localparam int ID_W  = 2;
    localparam int DR_W  = 11;

    logic                jt_tck = 1'b0;
    logic                jt_reset;
    logic                jt_sel;
    logic                jt_capture;
    logic                jt_shift;
    logic                jt_update;
    logic                jt_tdi;
    logic                jt_tdo;
    logic [N_SRC-1:0]    src_valid;
    logic [8*N_SRC-1:0]  src_data;
    logic [N_SRC-1:0]    src_ack;
    logic [DR_W-1:0]     rx_word;
    logic                rx_valid;
    logic                rx_err;

    always #5 jt_tck = ~jt_tck;

    jtag_tx_sched #(.N_SRC(N_SRC), .ID_W(ID_W)) dut (
        .jt_tck     (jt_tck),
        .jt_reset   (jt_reset),
        .jt_sel     (jt_sel),
        .jt_capture (jt_capture),
        .jt_shift   (jt_shift),
        .jt_update  (jt_update),
        .jt_tdi     (jt_tdi),
        .jt_tdo     (jt_tdo),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .src_ack    (src_ack),
        .rx_word    (rx_word),
        .rx_valid   (rx_valid),
        .rx_err     (rx_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [7:0]      srcq0[$];
    logic [7:0]      srcq1[$];
    int              last_gnt;
    logic [DR_W-1:0] rx_exp;
    int              ack_cnt0, ack_cnt1;
    int              stray;
    logic [1:0]      smp_ack;
    logic            smp_tdo;

    task automatic drive_src();
        src_valid = {srcq1.size() != 0, srcq0.size() != 0};
        src_data  = {(srcq1.size() != 0) ? srcq1[0] : 8'h00,
                     (srcq0.size() != 0) ? srcq0[0] : 8'h00};
    endtask

    // Winner of a capture, from the arbitration rule alone
    function automatic int pick(input logic [1:0] vld, input int last);
`ifdef JTAG_TX_STRICT_PRIO_EN
        for (int i = 0; i < N_SRC; i++) if (vld[i]) return i;
`else
        for (int k = 1; k <= N_SRC; k++) if (vld[(last + k) % N_SRC]) return (last + k) % N_SRC;
`endif
        return -1;
    endfunction

    // One TCK cycle: drive in low phase, sample before the edge, pop sources after it
    task automatic cyc(input logic c, input logic s, input logic u, input logic d, input logic sel);
        logic [7:0] tmp;
        @(negedge jt_tck);
        jt_sel = sel; jt_capture = c; jt_shift = s; jt_update = u; jt_tdi = d;
        #2;
        smp_ack = src_ack;
        smp_tdo = jt_tdo;
        if (!(c && sel) && smp_ack != 2'b00) stray++;
        if (smp_ack[0]) ack_cnt0++;
        if (smp_ack[1]) ack_cnt1++;
        @(posedge jt_tck);
        #1;
        if (smp_ack[0] && srcq0.size() != 0) tmp = srcq0.pop_front();
        if (smp_ack[1] && srcq1.size() != 0) tmp = srcq1.pop_front();
        drive_src();
    endtask

    // Predict the capture, return the frame the model expects on TDO
    task automatic model_capture(output logic [DR_W-1:0] frame, output logic [1:0] exp_ack);
        int g;
        g = pick(src_valid, last_gnt);
        frame   = '0;
        exp_ack = 2'b00;
        if (g >= 0) begin
            frame   = {(g == 0) ? srcq0[0] : srcq1[0], 2'(g), 1'b1};
            exp_ack = 2'b01 << g;
            last_gnt = g;
        end
    endtask

    // Full scan: capture, nsh shifts, update, idle; got = observed TDO bits
    task automatic run_frame(input int nsh, input logic [15:0] tdi, input string nm,
                             output logic [15:0] got);
        logic [DR_W-1:0] frame;
        logic [1:0]      exp_ack;
        logic            seq[$];
        logic [15:0]     exp;
        model_capture(frame, exp_ack);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (smp_ack !== exp_ack) begin
            errors++; $display("FAIL %s ack: got %b expected %b", nm, smp_ack, exp_ack);
        end
        for (int i = 0; i < DR_W; i++) seq.push_back(frame[i]);
        for (int i = 0; i < nsh; i++) seq.push_back(tdi[i]);
        got = '0; exp = '0;
        for (int i = 0; i < nsh; i++) begin
            cyc(1'b0, 1'b1, 1'b0, tdi[i], 1'b1);
            got[i] = smp_tdo;
            exp[i] = seq[i];
        end
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL %s tdo: got %h expected %h", nm, got, exp);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        if (nsh == DR_W) rx_exp = tdi[DR_W-1:0];
        checks++;
        if ({rx_valid, rx_err} !== {nsh == DR_W, nsh != DR_W}) begin
            errors++; $display("FAIL %s rx_strobe: got v=%b e=%b for %0d shifts", nm, rx_valid, rx_err, nsh);
        end
        checks++;
        if (rx_word !== rx_exp) begin
            errors++; $display("FAIL %s rx_word: got %h expected %h", nm, rx_word, rx_exp);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({rx_valid, rx_err} !== 2'b00) begin
            errors++; $display("FAIL %s strobe_len: got v=%b e=%b expected 0 0", nm, rx_valid, rx_err);
        end
    endtask

    task automatic test_reset();
        jt_reset = 1'b1;
        srcq0.push_back(8'h11); srcq1.push_back(8'h22);
        drive_src();
        @(negedge jt_tck);
        jt_sel = 1'b1; jt_capture = 1'b1;
        @(negedge jt_tck);
        #2;
        checks++;
        if ({jt_tdo, src_ack, rx_valid, rx_err} !== 5'b0) begin
            errors++; $display("FAIL reset_outs: got tdo=%b ack=%b v=%b e=%b expected all 0",
                               jt_tdo, src_ack, rx_valid, rx_err);
        end
        checks++;
        if (rx_word !== '0) begin
            errors++; $display("FAIL reset_rx_word: got %h expected 0", rx_word);
        end
        @(negedge jt_tck);
        jt_reset = 1'b0; jt_capture = 1'b0;
        srcq0.delete(); srcq1.delete();
        drive_src();
        last_gnt = N_SRC - 1;
        rx_exp   = '0;
    endtask

    // Two sources always valid: alternation (or id 0 only under fixed priority)
    task automatic test_rr_frames();
        logic [15:0] got;
        logic [10:0] exp2;
        int a0, a1;
        for (int i = 0; i < 4; i++) begin srcq0.push_back(8'hA5); srcq1.push_back(8'h3C); end
        drive_src();
        a0 = ack_cnt0; a1 = ack_cnt1;
`ifdef JTAG_TX_STRICT_PRIO_EN
        exp2 = 11'h529;
`else
        exp2 = 11'h1E3;
`endif
        run_frame(DR_W, 16'($urandom), "rr_f1", got);
        checks++;
        if (got[10:0] !== 11'h529) begin errors++; $display("FAIL rr_f1_const: got %h expected 529", got[10:0]); end
        run_frame(DR_W, 16'($urandom), "rr_f2", got);
        checks++;
        if (got[10:0] !== exp2) begin errors++; $display("FAIL rr_f2_const: got %h expected %h", got[10:0], exp2); end
        run_frame(DR_W, 16'($urandom), "rr_f3", got);
        checks++;
        if (got[2:0] !== 3'b001) begin errors++; $display("FAIL rr_f3_id: got %b expected 001", got[2:0]); end
        checks++;
        if ((ack_cnt0 - a0) + (ack_cnt1 - a1) !== 3) begin
            errors++; $display("FAIL rr_ack_total: got %0d expected 3", (ack_cnt0 - a0) + (ack_cnt1 - a1));
        end
        srcq0.delete(); srcq1.delete();
        drive_src();
    endtask

    task automatic test_no_source();
        logic [15:0] got;
        int a;
        a = ack_cnt0 + ack_cnt1;
        run_frame(DR_W, 16'h05A3, "nosrc", got);
        checks++;
        if (got !== 16'h0) begin errors++; $display("FAIL nosrc_tdo: got %h expected 0", got); end
        checks++;
        if (rx_word !== 11'h5A3) begin errors++; $display("FAIL nosrc_rx: got %h expected 5a3", rx_word); end
        checks++;
        if (ack_cnt0 + ack_cnt1 !== a) begin errors++; $display("FAIL nosrc_ack: got %0d expected %0d", ack_cnt0 + ack_cnt1, a); end
    endtask

    task automatic test_short_shift();
        logic [15:0] got;
        logic [DR_W-1:0] keep;
        int a;
        srcq0.push_back(8'($urandom));
        drive_src();
        keep = rx_exp;
        a = ack_cnt0 + ack_cnt1;
        run_frame(7, 16'($urandom), "short", got);
        checks++;
        if (rx_word !== keep) begin errors++; $display("FAIL short_hold: got %h expected %h", rx_word, keep); end
        checks++;
        if ((ack_cnt0 + ack_cnt1 - a) !== 1 || srcq0.size() != 0) begin
            errors++; $display("FAIL short_consume: got %0d acks expected 1", ack_cnt0 + ack_cnt1 - a);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [DR_W-1:0] frame;
        logic [1:0]      exp_ack;
        logic [15:0]     got;
        srcq0.push_back(8'h5C); srcq1.push_back(8'hC3);
        srcq0.push_back(8'h77); srcq1.push_back(8'h88);
        drive_src();
        model_capture(frame, exp_ack);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge jt_tck);
        jt_shift = 1'b0; jt_reset = 1'b1;
        #2;
        checks++;
        if ({jt_tdo, src_ack} !== 3'b0) begin
            errors++; $display("FAIL midrst_outs: got tdo=%b ack=%b expected 0", jt_tdo, src_ack);
        end
        @(negedge jt_tck);
        jt_reset = 1'b0;
        last_gnt = N_SRC - 1;
        rx_exp   = '0;
        // Update straight after reset finds no captured frame
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({rx_valid, rx_err} !== 2'b01) begin
            errors++; $display("FAIL midrst_idle_upd: got v=%b e=%b expected v=0 e=1", rx_valid, rx_err);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_frame(DR_W, 16'($urandom), "midrst_next", got);
        checks++;
        if (got[2:0] !== 3'b001) begin errors++; $display("FAIL midrst_src0: got %b expected 001", got[2:0]); end
        srcq0.delete(); srcq1.delete();
        drive_src();
    endtask

    // Deselected chain activity interleaved inside a selected scan
    task automatic test_desel();
        logic [DR_W-1:0] frame;
        logic [1:0]      exp_ack;
        logic            seq[$];
        logic [15:0]     tdi, got, exp;
        int              bad, s0;
        srcq1.push_back(8'($urandom)); srcq0.push_back(8'($urandom));
        drive_src();
        s0 = stray;
        tdi = 16'($urandom);
        model_capture(frame, exp_ack);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < DR_W; i++) seq.push_back(frame[i]);
        for (int i = 0; i < DR_W; i++) seq.push_back(tdi[i]);
        got = '0; exp = '0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'b0, tdi[i], 1'b1); got[i] = smp_tdo; exp[i] = seq[i];
        end
        bad = 0;
        for (int j = 0; j < 12; j++) begin
            cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            if (smp_tdo !== seq[4]) bad++;
            if (rx_valid !== 1'b0 || rx_err !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || stray != s0) begin
            errors++; $display("FAIL desel_quiet: got %0d disturbances, %0d acks expected 0", bad, stray - s0);
        end
        for (int i = 4; i < DR_W; i++) begin
            cyc(1'b0, 1'b1, 1'b0, tdi[i], 1'b1); got[i] = smp_tdo; exp[i] = seq[i];
        end
        checks++;
        if (got !== exp) begin errors++; $display("FAIL desel_tdo: got %h expected %h", got, exp); end
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        rx_exp = tdi[DR_W-1:0];
        checks++;
        if (rx_valid !== 1'b1 || rx_word !== rx_exp) begin
            errors++; $display("FAIL desel_rx: got v=%b word=%h expected v=1 word=%h", rx_valid, rx_word, rx_exp);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [15:0] got;
        int nsh, s0;
        s0 = stray;
        for (int f = 0; f < 16; f++) begin
            if ($urandom_range(0, 2) != 0 && srcq0.size() < 3) srcq0.push_back(8'($urandom));
            if ($urandom_range(0, 2) != 0 && srcq1.size() < 3) srcq1.push_back(8'($urandom));
            drive_src();
            nsh = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 13)) : DR_W;
            run_frame(nsh, 16'($urandom), "rand", got);
        end
        checks++;
        if (stray != s0) begin errors++; $display("FAIL rand_stray_ack: got %0d expected 0", stray - s0); end
    endtask

    initial begin
        jt_reset = 1'b1; jt_sel = 1'b0; jt_capture = 1'b0; jt_shift = 1'b0;
        jt_update = 1'b0; jt_tdi = 1'b0;
        ack_cnt0 = 0; ack_cnt1 = 0; stray = 0; last_gnt = N_SRC - 1; rx_exp = '0;
        drive_src();
        test_reset();
        test_rr_frames();
        test_no_source();
        test_short_shift();
        test_reset_mid_shift();
        test_desel();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/jtag_tx_sched.md
JTAG_TX_SCHED -- requirements
Module: jtag_tx_sched

Interface
REQ-001 Parameter N_SRC, default 2, is the number of TX requesters; legal values are 1..4.
REQ-002 Parameter ID_W, default 2, is the source-ID field width; it SHALL satisfy 2**ID_W >= N_SRC.
REQ-003 Frame width DR_W = 1+ID_W+8 (11 at defaults).
REQ-004 jt_tck  in  1  JTAG TCK; all logic is on its rising edge.
REQ-005 jt_reset  in  1  reset, asynchronous, active-high.
REQ-006 jt_sel  in  1  user chain selected.
REQ-007 jt_capture  in  1  Capture-DR state.
REQ-008 jt_shift  in  1  Shift-DR state.
REQ-009 jt_update  in  1  Update-DR state.
REQ-010 jt_tdi  in  1  serial data in.
REQ-011 jt_tdo  out  1  serial data out; equals dr[0].
REQ-012 src_valid  in  N_SRC  per-source word available (FWFT FIFO not-empty).
REQ-013 src_data  in  8*N_SRC  per-source head word; source i occupies bits [8i+7:8i].
REQ-014 src_ack  out  N_SRC  per-source one-TCK pop strobe.
REQ-015 rx_word  out  DR_W  last complete host word.
REQ-016 rx_valid  out  1  one-TCK strobe; rx_word is new.
REQ-017 rx_err  out  1  one-TCK strobe; Update-DR followed a wrong shift count.

Function
REQ-018 States: IDLE, LOADED, SHIFT, DONE; state SHALL change only when jt_sel=1.
- IDLE/DONE -> LOADED on jt_capture.
- LOADED/SHIFT -> SHIFT on jt_shift.
- any -> DONE on jt_update.
REQ-019 On a capture edge with jt_sel=1, the grant SHALL be the first valid source in round-robin order, starting at rr_ptr+1 mod N_SRC.
REQ-020 If a source is granted:
- dr loads {src_data[g], g[ID_W-1:0], 1'b1} (valid bit is the LSB).
- src_ack[g] is high combinationally in that same cycle only.
- rr_ptr is set to g on that edge.
REQ-021 If no source is valid, dr SHALL load all-zero, every src_ack bit SHALL stay 0, and rr_ptr SHALL be unchanged.
REQ-022 At most one src_ack bit is high in any cycle; src_ack SHALL never be high outside a capture cycle or while jt_reset=1.
REQ-023 On each shift edge, dr <= {jt_tdi, dr[DR_W-1:1]} and shift_cnt increments, saturating at DR_W+1.
REQ-024 shift_cnt SHALL clear to 0 on capture.
REQ-025 On an update edge with jt_sel=1:
- if shift_cnt == DR_W, rx_word <= dr and rx_valid pulses for one cycle;
- otherwise rx_word holds and rx_err pulses for one cycle.
REQ-026 Update without a preceding capture (state IDLE) SHALL raise rx_err.
REQ-027 Capture/shift/update edges with jt_sel=0 SHALL change no state, dr, shift_cnt, or rr_ptr.
REQ-028 A popped word SHALL NOT be re-offered: a capture followed by a short shift still consumes the word, and the loss is flagged by rx_err.
REQ-029 Latency: jt_tdo presents the frame LSB in the cycle after the capture edge.

Reset
REQ-030 While jt_reset=1, the following SHALL hold: state=IDLE, dr=0, shift_cnt=0, rr_ptr=N_SRC-1 (so source 0 wins first), rx_word=0, rx_valid=0, rx_err=0, src_ack=0, jt_tdo=0.
REQ-031 Reset asserted mid-shift SHALL abort the frame; the next capture re-arbitrates normally.

Configuration
REQ-032 Macro JTAG_TX_STRICT_PRIO_EN.
- Defined: the grant SHALL be the lowest-index valid source (fixed priority), and rr_ptr is unused.
- Undefined: round-robin arbitration as in REQ-019.

Structure
REQ-033 Package jtag_sched_pkg SHALL hold the state enum, the DR_W derivation, and the frame field offsets (VALID_BIT=0, ID_LSB=1, DATA_LSB=1+ID_W).
REQ-034 The arbitration SHALL be one sub-module, jtag_rr_arbiter: inputs req and ptr; outputs grant one-hot and grant index; purely combinational; with a strict-priority variant selected by the macro.

Verification
REQ-035 Two sources both valid (src0=0xA5, src1=0x3C), three 11-bit frames with defaults:
- frame 1 tdo = valid 1, id 0, data 0xA5;
- frame 2 = id 1, data 0x3C;
- frame 3 = id 0.
- src_ack pulses exactly once per frame.
REQ-036 No source valid: capture, 11 shifts -> tdo all zero and no src_ack; then update -> rx_valid=1 and rx_word equals the 11 shifted TDI bits (pattern 0x5A3).
REQ-037 Capture, 7 shifts, update -> rx_err=1, rx_valid=0, rx_word unchanged; the word granted at that capture was acked once.
REQ-038 jt_reset pulsed after 5 of 11 shifts -> dr=0, tdo=0, state IDLE; the next frame grants source 0.
REQ-039 jt_sel=0 while capture/shift/update toggle -> no src_ack, no rx_valid/rx_err, dr stable.
REQ-040 With JTAG_TX_STRICT_PRIO_EN defined and both sources continuously valid, three frames -> all three carry id 0.
